func_unit_sched: RTL

//   Round-robin scheduler sharing one multi-cycle function unit (FU: IW-bit arg -> OW-bit result)

---
 rtl/func_unit_sched.sv | 112 +++++++++++
 1 files changed

// File: rtl/func_unit_sched.sv
// func_unit_sched: round-robin arbiter sharing one multi-cycle function unit among NREQ requesters.
// Optional FU timeout abort enabled by defining FUNC_SCHED_TIMEOUT_EN.
module func_unit_sched #(
  parameter int NREQ       = 4,
  parameter int IW         = 2,
  parameter int OW         = 4,
  parameter int TMO_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*IW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [OW-1:0]     rsp_data,
  output logic              rsp_err,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              fu_start,
  output logic [IW-1:0]     fu_arg,
  input  logic              fu_done,
  input  logic [OW-1:0]     fu_result,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win;
  logic          found;
  int            idx;
`ifdef FUNC_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYCLES) + 1;
  logic [CW-1:0] cnt;
  logic          expire;
  assign expire = cnt == CW'(TMO_CYCLES - 1);
`else
  assign rsp_err = 1'b0;
`endif
  assign busy      = state != IDLE;
  assign req_ready = (state == IDLE && found) ? (NREQ'(1) << win) : '0;
  // rotating priority search starting just after the last served requester
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end
  // transaction sequencing: accept, start FU, await result, hand response back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= PW'(NREQ - 1);
      owner     <= '0;
      fu_start  <= 1'b0;
      fu_arg    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
`ifdef FUNC_SCHED_TIMEOUT_EN
      rsp_err   <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      fu_start <= 1'b0;
      case (state)
        IDLE: if (found) begin
          owner    <= win;
          fu_arg   <= req_data[int'(win)*IW +: IW];
          fu_start <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT;
`ifdef FUNC_SCHED_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          if (fu_done) begin
            rsp_data  <= fu_result;
            rsp_valid <= NREQ'(1) << owner;
            state     <= RESP;
`ifdef FUNC_SCHED_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (expire) begin
            rsp_data  <= '1;
            rsp_err   <= 1'b1;
            rsp_valid <= NREQ'(1) << owner;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        default: if (rsp_ready[owner]) begin
          rsp_valid <= '0;
          ptr       <= owner;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
